alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multicycle execute unit that merges ALU-control decoding with the arithmetic datapath. It adds the RV32M multiply/divide group, computed iteratively, on top of the base integer operations. It sits between the register-operand latches (A/B) and ALUOut in the multicycle datapath. The main FSM issues one operation with `start` and waits for `done`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHAMT_W`, $clog2(XLEN): number of low bits of `b` used as the shift amount.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  operation request; sampled only in IDLE.
- `ALUOp`  in  2  class code from the main control: 00 = ADD, 01 = SUB (branch compare), 10 = R-type decode, 11 = pass `b` (LUI).
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7.
- `a`  in  XLEN  operand 1 (rs1).
- `b`  in  XLEN  operand 2 (rs2 or immediate).
- `result`  out  XLEN  registered result; holds until the next accepted `start`.
- `zero`  out  1  registered; equals (`result` == 0).
- `busy`  out  1  high from the cycle after acceptance until `done` is asserted.
- `done`  out  1  one-cycle pulse; `result` and `zero` are valid in this cycle.

## Operation
- FSM states:
  - IDLE: `start` taken with ALUOp ≠ 10, or with funct7 ≠ 0000001 → DONE.
  - IDLE: `start` taken with ALUOp = 10 and funct7 = 0000001 → CALC.
  - CALC → DONE after XLEN iterations.
  - DONE → IDLE unconditionally.
- Acceptance: `a`, `b`, `ALUOp`, `funct3` and `funct7` are captured on the accepting edge. Later changes on these inputs are ignored until the next acceptance.
- `start` in CALC or DONE is ignored. It is not queued.
- Base decode, ALUOp = 10 with funct7 ≠ 0000001:
  - funct3 000: SUB if funct7 = 0100000, else ADD.
  - 001: SLL. 010: SLT (signed). 011: SLTU. 100: XOR.
  - 101: SRA if funct7 = 0100000, else SRL.
  - 110: OR. 111: AND.
  - Shift amount is `b[SHAMT_W-1:0]`.
  - SLT and SLTU return 0 or 1, zero-extended to XLEN.
- M decode, ALUOp = 10 with funct7 = 0000001, by funct3:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high half, signed × signed.
  - 010 MULHSU: high half, signed `a` × unsigned `b`.
  - 011 MULHU: high half, unsigned × unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply method:
  - Operate on magnitudes with shift-add, one bit per cycle, into a 2·XLEN accumulator.
  - Negate the full product if the operand signs differ (signed modes only).
- Divide method:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide special cases (must not iterate into garbage; the latency is still the full CALC length):
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = `a`; remainder = 0.
- Arithmetic wraps modulo 2^XLEN. No overflow flag.

## Timing
- Cycle 0 is the edge on which `start` is accepted.
- Base ops and ALUOp 00/01/11: `done` = 1 and `result` valid in cycle 1. Latency is 1.
- M ops: `busy` is high in cycles 1..XLEN; `done` = 1 and `result` valid in cycle XLEN+1. Latency is XLEN+1.
- The earliest next acceptance is the cycle after `done`, i.e. back-to-back base ops every 2 cycles.
- Reset values: `result` = 0, `zero` = 1, `busy` = 0, `done` = 0, state IDLE, iteration counter 0.
- `rst` during CALC or DONE aborts the operation on that edge. No `done` pulse is issued for the aborted operation.
- `rst` and `start` asserted together: reset wins and the request is dropped.

## Test plan
- Reset, then `start` with ALUOp = 10, funct3 = 000, funct7 = 0100000, a = 5, b = 7 → `done` in cycle 1, `result` = 0xFFFFFFFE, `zero` = 0.
- ALUOp = 10, funct3 = 101, funct7 = 0100000, a = 0x80000000, b = 4 → `result` = 0xF8000000. Same operands with funct7 = 0 → 0x08000000.
- MULH with a = 0xFFFFFFFF, b = 0xFFFFFFFF → `busy` for 32 cycles, `done` in cycle 33, `result` = 0. MULHU on the same operands → 0xFFFFFFFE. MUL → 1.
- DIV with a = 0x80000000, b = 0xFFFFFFFF → 0x80000000. REM on the same operands → 0, `zero` = 1. DIVU with b = 0 → 0xFFFFFFFF. REMU with a = 9, b = 0 → 9.
- DIV with a = −7, b = 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. A `start` pulse during CALC is ignored and the result is unchanged.
- Assert `rst` in cycle 10 of a DIVU → no `done` pulse; outputs return to reset values. The next ADD (a = 1, b = 2) completes with `result` = 3.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Handshake/operand bundle between the main control FSM and alu_exec_unit.
//   master : drives start, ALUOp, funct3, funct7, a, b; observes result/zero/busy/done
//   slave  : the execute unit; the mirror image of master
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;
  logic            done;

  modport master (
    output start, ALUOp, funct3, funct7, a, b,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, ALUOp, funct3, funct7, a, b,
    output result, zero, busy, done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multicycle execute unit: ALU-control decode plus integer datapath, with the
// RV32M multiply/divide group computed one bit per cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_exec_unit_if.slave -- start/ALUOp/funct3/funct7/a/b in,
//          result/zero/busy/done out (all outputs registered)
// Base ops finish one cycle after acceptance; M ops take XLEN+1 cycles.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Iterative datapath: acc holds {hi, lo}. Multiply: hi = partial product,
  // lo = remaining multiplier bits. Divide: hi = partial remainder,
  // lo = dividend bits shifting out / quotient bits shifting in.
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN-1:0]    mcand_q;   // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0]    a_q;       // raw a, needed for remainder on divide-by-zero / overflow
  logic [2:0]         f3_q;
  logic               neg_q;     // negate product / quotient
  logic               neg_rem_q; // negate remainder
  logic               div0_q;
  logic               ovf_q;

  // ---------------- base ALU, evaluated on the accepting edge ----------------
  logic [XLEN-1:0]    base_res;
  logic [SHAMT_W-1:0] shamt;
  logic               alt;
  logic               is_m;

  assign shamt = bus.b[SHAMT_W-1:0];
  assign alt   = (bus.funct7 == 7'b0100000);
  assign is_m  = (bus.ALUOp == 2'b10) && (bus.funct7 == 7'b0000001);

  always_comb begin
    // NOTE: default first so every path assigns base_res and no latch is inferred.
    base_res = '0;
    unique case (bus.ALUOp)
      2'b00: base_res = bus.a + bus.b;
      2'b01: base_res = bus.a - bus.b;
      2'b11: base_res = bus.b;
      default: begin
        unique case (bus.funct3)
          3'b000: base_res = alt ? (bus.a - bus.b) : (bus.a + bus.b);
          3'b001: base_res = bus.a << shamt;
          3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
          3'b011: base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
          3'b100: base_res = bus.a ^ bus.b;
          3'b101: base_res = alt ? XLEN'($signed(bus.a) >>> shamt) : (bus.a >> shamt);
          3'b110: base_res = bus.a | bus.b;
          default: base_res = bus.a & bus.b;
        endcase
      end
    endcase
  end

  // ---------------- M-op setup: operand signs and magnitudes ----------------
  logic            is_div;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign is_div = bus.funct3[2];
  // MULH (x01) treats both operands as signed, MULHSU (x10) only a; MUL's low
  // half is sign-independent so it runs unsigned. DIV/REM are signed, *U are not.
  assign sign_a = bus.a[XLEN-1] &&
                  (is_div ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10));
  assign sign_b = bus.b[XLEN-1] &&
                  (is_div ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01));
  assign mag_a  = sign_a ? -bus.a : bus.a;
  assign mag_b  = sign_b ? -bus.b : bus.b;

  // ---------------- one iteration step ----------------
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = shifted - {1'b0, mcand_q};
    acc_step = '0;
    if (f3_q[2]) begin
      // Restoring step: keep the difference only if it did not go negative.
      acc_step[2*XLEN-1:XLEN] = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      acc_step[XLEN-1:0]      = {acc_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      // Shift-add step: carry out of the add becomes the new top bit.
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  // ---------------- final sign fix-up and special cases ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   m_res;

  always_comb begin
    prod  = neg_q ? -acc_step : acc_step;
    quo   = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem   = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (div0_q) begin
      quo = '1;
      rem = a_q;
    end else if (ovf_q) begin
      quo = a_q;
      rem = '0;
    end
    if (f3_q[2])
      m_res = f3_q[1] ? rem : quo;
    else
      m_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            if (is_m) begin
              state    <= S_CALC;
              cnt      <= '0;
              bus.busy <= 1'b1;
            end else begin
              state      <= S_DONE;
              bus.result <= base_res;
              bus.zero   <= (base_res == '0);
              bus.done   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1)) begin
            state      <= S_DONE;
            bus.result <= m_res;
            bus.zero   <= (m_res == '0);
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers are fully rewritten on every accepted M op before being
  // read.
  // NOTE: they are deliberately left out of reset; only control state needs a
  // known value.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start && is_m) begin
      acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      mcand_q   <= is_div ? mag_b : mag_a;
      a_q       <= bus.a;
      f3_q      <= bus.funct3;
      neg_q     <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      div0_q    <= (bus.b == '0);
      ovf_q     <= is_div && !bus.funct3[0] &&
                   (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    end else if (state == S_CALC) begin
      acc_q <= acc_step;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN = 32).
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, scramble the inputs once accepted, and track
  // latency and busy cycles until done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [XLEN-1:0] a_in,
                        input logic [XLEN-1:0] b_in, input logic [XLEN-1:0] exp_res,
                        input logic exp_zero, input int exp_lat, input bit mid_start);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ALUOp  = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.a      = a_in;
    bus.b      = b_in;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.ALUOp  = 2'($urandom_range(0, 3));
    bus.funct3 = ~f3;
    bus.funct7 = 7'b0000001;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      bus.start = (mid_start && lat == 5);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_hold"}, 64'(bus.result), 64'(exp_res));
  endtask

  initial begin
    int  n;
    bit  saw_done;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.ALUOp  = 2'b00;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000000;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // Base decode
    run_op("sub",    2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 0);
    run_op("sra",    2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0);
    run_op("srl",    2'b10, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 0);
    run_op("sll",    2'b10, 3'b001, 7'b0000000, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b0, 1, 0);
    run_op("slt",    2'b10, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
    run_op("sltu",   2'b10, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0);
    run_op("xor",    2'b10, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1, 0);
    run_op("or",     2'b10, 3'b110, 7'b0000000, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1, 0);
    run_op("and",    2'b10, 3'b111, 7'b0000000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1, 0);
    run_op("aop_sub",2'b01, 3'b111, 7'b0000000, 32'd9, 32'd9, 32'd0, 1'b1, 1, 0);
    run_op("aop_add_m7", 2'b00, 3'b011, 7'b0000001, 32'd10, 32'd20, 32'd30, 1'b0, 1, 0);
    run_op("lui",    2'b11, 3'b000, 7'b0000000, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1, 0);

    // Multiply
    run_op("mulh",   2'b10, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 33, 0);
    run_op("mulhu",  2'b10, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);
    run_op("mul",    2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 0);
    run_op("mulhsu", 2'b10, 3'b010, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0);

    // Divide, including special cases
    run_op("div_ovf",  2'b10, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 0);
    run_op("rem_ovf",  2'b10, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 33, 0);
    run_op("divu_z",   2'b10, 3'b101, 7'b0000001, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("remu_z",   2'b10, 3'b111, 7'b0000001, 32'd9, 32'd0, 32'd9, 1'b0, 33, 0);
    run_op("div_neg",  2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1);
    run_op("div_negb", 2'b10, 3'b100, 7'b0000001, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("rem_negb", 2'b10, 3'b110, 7'b0000001, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33, 0);
    run_op("divu",     2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0);
    run_op("rem_neg",  2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1);

    // Reset in cycle 10 of a DIVU aborts it
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ALUOp  = 2'b10;
    bus.funct3 = 3'b101;
    bus.funct7 = 7'b0000001;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done  = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (bus.done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_zero", 64'(bus.zero), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    n = 0;
    while (n < 40) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge clk);
      n++;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op("add_after_rst", 2'b00, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0);

    // rst and start together: reset wins, nothing is accepted
    @(negedge clk);
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.ALUOp  = 2'b00;
    bus.a      = 32'd4;
    bus.b      = 32'd4;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_done", 64'(bus.done), 64'd0);
    check("rst_start_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    check("rst_start_done2", 64'(bus.done), 64'd0);
    check("rst_start_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
